lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit in the Memory part of the RV32I core; consumes the ALU result as the effective address.
- Issues one data-memory transaction per load/store over a req/ack bus.
- Stalls the pipeline until the transaction completes.
- Returns sign- or zero-extended load data, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ waiting for i_MemAck before bus error; 0 disables timeout.

Ports:
- i_Clk  in  1  core clock
- i_Rst_n  in  1  asynchronous active-low reset
- i_Valid  in  1  Memory-part instruction valid this cycle
- i_MemRead  in  1  instruction is a load (from DECODE)
- i_MemWrite  in  1  instruction is a store (from DECODE)
- i_Funct3_3  in  3  Inst[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_ALUResult_32  in  32  effective address
- i_StoreData_32  in  32  rs2 value
- o_Stall  out  1  freeze upstream pipeline
- o_MemReq  out  1  bus request
- o_MemWe  out  1  1 = write
- o_MemAddr_32  out  32  word address; bits [1:0] always 0
- o_MemBe_4  out  4  byte enables
- o_MemWdata_32  out  32  lane-replicated store data
- i_MemAck  in  1  bus completion, single-cycle pulse
- i_MemRdata_32  in  32  read word, valid with i_MemAck
- o_LoadData_32  out  32  extended load result
- o_LoadValid  out  1  one-cycle pulse, o_LoadData_32 valid
- o_MisalignExc  out  1  one-cycle pulse: misaligned or illegal access
- o_BusErr  out  1  one-cycle pulse: timeout

Behaviour:
- Reset:
  - Asynchronous, active-low: clock i_Clk, reset i_Rst_n.
  - All outputs 0, state IDLE, timeout counter 0.
  - Reset mid-transaction aborts immediately: o_MemReq drops asynchronously and no pulse is emitted.
- States: IDLE, REQ, RESP, EXC.
- Access decode: access = i_Valid & (i_MemRead | i_MemWrite).
- Illegal access, any of:
  - i_MemRead & i_MemWrite both set
  - funct3 011/110/111
  - store funct3 1xx
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=00.
- IDLE:
  - Legal, aligned access: latch addr, funct3, we, be, wdata; go to REQ.
  - Illegal or misaligned access: go to EXC; no bus activity.
  - Otherwise stay in IDLE.
- REQ:
  - o_MemReq=1, with address, we, be and wdata held stable.
  - On i_MemAck: a load captures the extracted rdata; go to RESP.
  - Counter increments each REQ cycle without ack; if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES, go to EXC with the bus-error flag set.
  - o_MemReq deasserts in the cycle after ack or timeout.
- RESP: o_LoadValid=1 for loads only (stores produce no pulse); return to IDLE.
- EXC: pulse o_MisalignExc or o_BusErr; return to IDLE.
- Stall:
  - o_Stall = (IDLE & access) | REQ, combinational.
  - Deasserts in RESP/EXC so the instruction retires exactly once.
- Latency: minimum 3 cycles from accept to o_LoadValid (accept edge, ack sampled in first REQ cycle, RESP).
- Acks outside REQ are ignored.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Loads:
  - Select byte/half by addr[1:0] / addr[1].
  - B/H sign-extend; BU/HU zero-extend.
  - Reads always drive be = 1111.
- o_LoadData_32 holds its last value until the next load completes.

Decomposition:
- Shared include rv32i_defines.vh: funct3 load/store codes, LSU state encodings (2-bit), TIMEOUT default.
- One combinational sub-module lsu_align: store be/wdata generation, load extract and extend, misalign/illegal detection.
- The FSM, latches and counter stay in lsu.

Test Plan:
- LW addr 0x0000_1004, ack on 2nd REQ cycle with rdata 0xDEADBEEF -> o_MemAddr_32=0x1004, be=1111, o_LoadData_32=0xDEADBEEF with o_LoadValid pulse, o_Stall high 3 cycles.
- LB addr 0x103, rdata 0x80FF_0000 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF; LHU -> 0x000080FF.
- SB addr 0x2001 rs2 0x12345678 -> be=0010, wdata=0x78787878, we=1; SH addr 0x2002 -> be=1100, wdata=0x56785678; no o_LoadValid.
- LW addr 0x1002, and SH addr 0x1001 -> o_MisalignExc pulse next cycle, o_MemReq never asserted, stall 1 cycle.
- TIMEOUT_CYCLES=4, no ack -> o_MemReq high 4 cycles, then o_BusErr pulse and return to IDLE; a late ack afterwards is ignored.
- Reset asserted during REQ -> o_MemReq and o_Stall low immediately; after release the next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM state
// encoding and the default bus timeout.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_EXC  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Pure combinational lane logic: store byte enables and replicated write data,
// access legality/alignment checks, and load byte/half extraction with extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_read,
    input  logic        is_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        illegal,
    output logic        misaligned,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        if (is_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Stores have no unsigned variants, so any funct3[2] store is illegal.
    assign illegal = (is_read & is_write)
                   | (funct3 == 3'b011)
                   | (funct3[2:1] == 2'b11)
                   | (is_write & funct3[2]);

    assign misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0])
                      | ((funct3 == F3_W) & (addr_lo != 2'b00));

    always_comb begin
        byte_sel = rdata[7:0];
        case (load_addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: ;
        endcase
        half_sel = load_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (load_funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one req/ack bus transaction per memory instruction,
// stalling the pipeline until it completes, faults or times out.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Valid,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_Funct3_3,
    input  logic [31:0] i_ALUResult_32,
    input  logic [31:0] i_StoreData_32,
    output logic        o_Stall,
    output logic        o_MemReq,
    output logic        o_MemWe,
    output logic [31:0] o_MemAddr_32,
    output logic [3:0]  o_MemBe_4,
    output logic [31:0] o_MemWdata_32,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemRdata_32,
    output logic [31:0] o_LoadData_32,
    output logic        o_LoadValid,
    output logic        o_MisalignExc,
    output logic        o_BusErr
);

    lsu_state_e  state, state_next;
    logic [31:0] cnt, cnt_next;
    logic        bus_err_q, bus_err_next;
    logic [31:0] addr_q, wdata_q, load_data_q;
    logic [2:0]  funct3_q;
    logic [3:0]  be_q;
    logic        we_q;

    logic        access, accept, load_done;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_ext;
    logic        illegal, misaligned;

    assign access = i_Valid & (i_MemRead | i_MemWrite);

    lsu_align u_align (
        .is_read      (i_MemRead),
        .is_write     (i_MemWrite),
        .funct3       (i_Funct3_3),
        .addr_lo      (i_ALUResult_32[1:0]),
        .store_data   (i_StoreData_32),
        .be           (be_c),
        .wdata        (wdata_c),
        .illegal      (illegal),
        .misaligned   (misaligned),
        .load_funct3  (funct3_q),
        .load_addr_lo (addr_q[1:0]),
        .rdata        (i_MemRdata_32),
        .load_data    (load_ext)
    );

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bus_err_next = bus_err_q;
        accept       = 1'b0;
        load_done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (access) begin
                    if (illegal | misaligned) begin
                        state_next   = ST_EXC;
                        bus_err_next = 1'b0;
                    end else begin
                        state_next = ST_REQ;
                        cnt_next   = '0;
                        accept     = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (i_MemAck) begin
                    state_next = ST_RESP;
                    cnt_next   = '0;
                    load_done  = ~we_q;
                end else begin
                    cnt_next = cnt + 32'd1;
                    if ((TIMEOUT_CYCLES != 0) && (cnt + 32'd1 == TIMEOUT_CYCLES)) begin
                        state_next   = ST_EXC;
                        cnt_next     = '0;
                        bus_err_next = 1'b1;
                    end
                end
            end
            ST_RESP: state_next = ST_IDLE;
            ST_EXC:  state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bus_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            load_data_q <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bus_err_q <= bus_err_next;
            if (accept) begin
                addr_q   <= i_ALUResult_32;
                wdata_q  <= wdata_c;
                funct3_q <= i_Funct3_3;
                be_q     <= be_c;
                we_q     <= i_MemWrite;
            end
            if (load_done) begin
                load_data_q <= load_ext;
            end
        end
    end

    // Outputs decode from registered state, so reset clears them asynchronously.
    assign o_MemReq      = (state == ST_REQ);
    assign o_Stall       = ((state == ST_IDLE) & access) | (state == ST_REQ);
    assign o_MemWe       = we_q;
    assign o_MemAddr_32  = {addr_q[31:2], 2'b00};
    assign o_MemBe_4     = be_q;
    assign o_MemWdata_32 = wdata_q;
    assign o_LoadData_32 = load_data_q;
    assign o_LoadValid   = (state == ST_RESP) & ~we_q;
    assign o_MisalignExc = (state == ST_EXC) & ~bus_err_q;
    assign o_BusErr      = (state == ST_EXC) & bus_err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// compared against an arithmetic reference model of the access rules.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] alu_result = '0, store_data = '0;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] load_data;
    logic        load_valid, misalign_exc, bus_err;

    always #5 clk = ~clk;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .i_Clk          (clk),
        .i_Rst_n        (rst_n),
        .i_Valid        (valid),
        .i_MemRead      (mem_read),
        .i_MemWrite     (mem_write),
        .i_Funct3_3     (funct3),
        .i_ALUResult_32 (alu_result),
        .i_StoreData_32 (store_data),
        .o_Stall        (stall),
        .o_MemReq       (mem_req),
        .o_MemWe        (mem_we),
        .o_MemAddr_32   (mem_addr),
        .o_MemBe_4      (mem_be),
        .o_MemWdata_32  (mem_wdata),
        .i_MemAck       (mem_ack),
        .i_MemRdata_32  (mem_rdata),
        .o_LoadData_32  (load_data),
        .o_LoadValid    (load_valid),
        .o_MisalignExc  (misalign_exc),
        .o_BusErr       (bus_err)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_last_ld = '0;

    typedef struct {
        int          req_cycles;
        int          stall_cycles;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        stable;
        int          lv_count;
        int          lv_cycle;
        int          mis_count;
        int          mis_cycle;
        int          berr_count;
        int          berr_cycle;
        logic [31:0] ld_end;
    } obs_t;

    typedef struct {
        logic        exc;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    obs_t obs;

    // Reference model: derive the access outcome directly from size/offset arithmetic.
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] rs2,
                                   input logic [31:0] rdata);
        exp_t        m;
        int          size;
        int          off;
        logic [31:0] mask, sh, val;
        size = int'(f3[1:0]);
        off  = int'(addr[1:0]);
        m.exc = (rd && wr) || (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3 >= 3'd4)
             || ((addr & 32'((1 << size) - 1)) != 0);
        if (!wr)            m.be = 4'hF;
        else if (size == 0) m.be = 4'(1 << off);
        else if (size == 1) m.be = 4'(3 << off);
        else                m.be = 4'hF;
        if (size == 0)      m.wdata = {24'd0, rs2[7:0]} * 32'h0101_0101;
        else if (size == 1) m.wdata = {16'd0, rs2[15:0]} * 32'h0001_0001;
        else                m.wdata = rs2;
        mask = (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        sh   = rdata >> (8 * off);
        val  = sh & mask;
        if (!f3[2] && ((val & ((mask >> 1) + 32'd1)) != 0)) val = val | ~mask;
        m.ld = val;
        return m;
    endfunction

    // Drives one instruction and records what the bus and pulse outputs did over a fixed window.
    // ack_at: REQ cycle (1-based) that gets the ack, 0 = never. late_ack: window cycle for a stray ack.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input int ack_at, input logic [31:0] rdata, input int late_ack);
        obs.req_cycles = 0;  obs.stall_cycles = 0; obs.addr = '0; obs.be = '0;
        obs.we = 1'b0;       obs.wdata = '0;       obs.stable = 1'b1;
        obs.lv_count = 0;    obs.lv_cycle = -1;    obs.mis_count = 0; obs.mis_cycle = -1;
        obs.berr_count = 0;  obs.berr_cycle = -1;  obs.ld_end = '0;
        @(negedge clk);
        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; store_data = rs2; mem_ack = 1'b0;
        #1;
        if (stall) obs.stall_cycles++;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
            funct3 = 3'($urandom); alu_result = $urandom; store_data = $urandom;
            #1;
            if (stall) obs.stall_cycles++;
            if (load_valid)   begin obs.lv_count++;   obs.lv_cycle = c;   end
            if (misalign_exc) begin obs.mis_count++;  obs.mis_cycle = c;  end
            if (bus_err)      begin obs.berr_count++; obs.berr_cycle = c; end
            if (mem_req) begin
                obs.req_cycles++;
                if (obs.req_cycles == 1) begin
                    obs.addr = mem_addr; obs.be = mem_be; obs.we = mem_we; obs.wdata = mem_wdata;
                end else if (mem_addr !== obs.addr || mem_be !== obs.be ||
                             mem_we !== obs.we || mem_wdata !== obs.wdata) begin
                    obs.stable = 1'b0;
                end
                mem_ack   = (obs.req_cycles == ack_at);
                mem_rdata = mem_ack ? rdata : $urandom;
            end else begin
                mem_ack   = (c == late_ack);
                mem_rdata = $urandom;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        obs.ld_end = load_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({mem_req, mem_we, load_valid, misalign_exc, bus_err, stall, mem_be, mem_addr, mem_wdata, load_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b we=%b lv=%b mis=%b berr=%b stall=%b be=%h addr=%h wdata=%h ld=%h required all zero",
                     mem_req, mem_we, load_valid, misalign_exc, bus_err, stall, mem_be, mem_addr, mem_wdata, load_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
        do_op(1'b1, 1'b0, F3_W, 32'h0000_1004, 32'h0, 2, 32'hDEAD_BEEF, 0);
        exp_last_ld = 32'hDEAD_BEEF;
        checks++;
        if (obs.addr !== 32'h1004 || obs.be !== 4'hF || obs.we !== 1'b0) begin
            errors++;
            $display("FAIL lw_bus got addr=%h be=%b we=%b required addr=00001004 be=1111 we=0", obs.addr, obs.be, obs.we);
        end
        checks++;
        if (obs.ld_end !== 32'hDEAD_BEEF || obs.lv_count != 1 || obs.lv_cycle != 3) begin
            errors++;
            $display("FAIL lw_data got ld=%h pulses=%0d at=%0d required ld=deadbeef pulses=1 at=3", obs.ld_end, obs.lv_count, obs.lv_cycle);
        end
        checks++;
        if (obs.stall_cycles != 3 || obs.req_cycles != 2) begin
            errors++;
            $display("FAIL lw_stall got stall=%0d req=%0d required stall=3 req=2", obs.stall_cycles, obs.req_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, 1, 32'h80FF_0000, 0);
            exp_last_ld = exps[i];
            checks++;
            if (obs.ld_end !== exps[i] || obs.lv_count != 1) begin
                errors++;
                $display("FAIL subword_load[%0d] got ld=%h pulses=%0d required ld=%h pulses=1", i, obs.ld_end, obs.lv_count, exps[i]);
            end
        end
    endtask

    task automatic test_stores();
        do_op(1'b0, 1'b1, F3_B, 32'h0000_2001, 32'h1234_5678, 1, 32'h0, 0);
        checks++;
        if (obs.be !== 4'b0010 || obs.wdata !== 32'h7878_7878 || obs.we !== 1'b1 || obs.addr !== 32'h2000) begin
            errors++;
            $display("FAIL sb_bus got be=%b wdata=%h we=%b addr=%h required be=0010 wdata=78787878 we=1 addr=00002000", obs.be, obs.wdata, obs.we, obs.addr);
        end
        checks++;
        if (obs.lv_count != 0 || obs.ld_end !== exp_last_ld) begin
            errors++;
            $display("FAIL sb_no_load got pulses=%0d ld=%h required pulses=0 ld=%h", obs.lv_count, obs.ld_end, exp_last_ld);
        end
        do_op(1'b0, 1'b1, F3_H, 32'h0000_2002, 32'h1234_5678, 2, 32'h0, 0);
        checks++;
        if (obs.be !== 4'b1100 || obs.wdata !== 32'h5678_5678 || obs.we !== 1'b1 || !obs.stable) begin
            errors++;
            $display("FAIL sh_bus got be=%b wdata=%h we=%b stable=%b required be=1100 wdata=56785678 we=1 stable=1", obs.be, obs.wdata, obs.we, obs.stable);
        end
        checks++;
        if (obs.lv_count != 0) begin
            errors++;
            $display("FAIL sh_no_load got pulses=%0d required 0", obs.lv_count);
        end
    endtask

    task automatic test_misaligned();
        logic        rds [2] = '{1'b1, 1'b0};
        logic [2:0]  f3s [2] = '{F3_W, F3_H};
        logic [31:0] ads [2] = '{32'h1002, 32'h1001};
        for (int i = 0; i < 2; i++) begin
            do_op(rds[i], !rds[i], f3s[i], ads[i], 32'hA5A5_A5A5, 1, 32'h0, 0);
            checks++;
            if (obs.mis_count != 1 || obs.mis_cycle != 1 || obs.req_cycles != 0 || obs.stall_cycles != 1 || obs.lv_count != 0) begin
                errors++;
                $display("FAIL misalign[%0d] got mis=%0d at=%0d req=%0d stall=%0d lv=%0d required mis=1 at=1 req=0 stall=1 lv=0",
                         i, obs.mis_count, obs.mis_cycle, obs.req_cycles, obs.stall_cycles, obs.lv_count);
            end
        end
    endtask

    task automatic test_timeout();
        do_op(1'b1, 1'b0, F3_W, 32'h0000_3000, 32'h0, 0, 32'h0, 7);
        checks++;
        if (obs.req_cycles != 4 || obs.berr_count != 1 || obs.berr_cycle != 5) begin
            errors++;
            $display("FAIL timeout got req=%0d berr=%0d at=%0d required req=4 berr=1 at=5", obs.req_cycles, obs.berr_count, obs.berr_cycle);
        end
        checks++;
        if (obs.lv_count != 0 || obs.mis_count != 0 || obs.stall_cycles != 5 || obs.ld_end !== exp_last_ld) begin
            errors++;
            $display("FAIL timeout_side got lv=%0d mis=%0d stall=%0d ld=%h required lv=0 mis=0 stall=5 ld=%h",
                     obs.lv_count, obs.mis_count, obs.stall_cycles, obs.ld_end, exp_last_ld);
        end
        do_op(1'b1, 1'b0, F3_W, 32'h0000_3004, 32'h0, 1, 32'h0BAD_F00D, 0);
        exp_last_ld = 32'h0BAD_F00D;
        checks++;
        if (obs.ld_end !== 32'h0BAD_F00D || obs.lv_count != 1 || obs.berr_count != 0) begin
            errors++;
            $display("FAIL after_timeout got ld=%h lv=%0d berr=%0d required ld=0badf00d lv=1 berr=0", obs.ld_end, obs.lv_count, obs.berr_count);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        @(negedge clk);
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; alu_result = 32'h4000; mem_ack = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre got req=%b required 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_async got req=%b stall=%b ld=%h required 0 0 00000000", mem_req, stall, load_data);
        end
        exp_last_ld = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            #1;
            if (load_valid || misalign_exc || bus_err || mem_req) pulses++;
        end
        rst_n = 1'b1;
        mem_ack = 1'b0;
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got %0d active cycles required 0", pulses);
        end
        do_op(1'b1, 1'b0, F3_W, 32'h0000_4008, 32'h0, 1, 32'hCAFE_1234, 0);
        exp_last_ld = 32'hCAFE_1234;
        checks++;
        if (obs.ld_end !== 32'hCAFE_1234 || obs.lv_count != 1 || obs.lv_cycle != 2 || obs.addr !== 32'h4008) begin
            errors++;
            $display("FAIL rst_mid_after got ld=%h lv=%0d at=%0d addr=%h required ld=cafe1234 lv=1 at=2 addr=00004008",
                     obs.ld_end, obs.lv_count, obs.lv_cycle, obs.addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int          kind, ack_at, exp_req, exp_stall;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] addr, rs2, rdata;
            exp_t        e;
            kind   = int'($urandom_range(0, 9));
            rd     = (kind < 5) || (kind == 9);
            wr     = (kind >= 5);
            f3     = 3'($urandom);
            addr   = $urandom;
            rs2    = $urandom;
            rdata  = $urandom;
            ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
            e      = model(rd, wr, f3, addr, rs2, rdata);
            do_op(rd, wr, f3, addr, rs2, ack_at, rdata, int'($urandom_range(6, 12)));
            exp_req   = e.exc ? 0 : (ack_at == 0) ? int'(TO) : ack_at;
            exp_stall = e.exc ? 1 : exp_req + 1;
            if (!e.exc && ack_at != 0 && rd) exp_last_ld = e.ld;
            checks++;
            if (obs.req_cycles != exp_req || obs.stall_cycles != exp_stall) begin
                errors++;
                $display("FAIL rnd_timing[%0d] got req=%0d stall=%0d required req=%0d stall=%0d", i, obs.req_cycles, obs.stall_cycles, exp_req, exp_stall);
            end
            checks++;
            if (obs.mis_count != int'(e.exc) || obs.berr_count != int'(!e.exc && ack_at == 0) ||
                obs.lv_count != int'(!e.exc && ack_at != 0 && rd)) begin
                errors++;
                $display("FAIL rnd_pulses[%0d] got mis=%0d berr=%0d lv=%0d required mis=%0d berr=%0d lv=%0d", i,
                         obs.mis_count, obs.berr_count, obs.lv_count, int'(e.exc), int'(!e.exc && ack_at == 0), int'(!e.exc && ack_at != 0 && rd));
            end
            checks++;
            if (obs.ld_end !== exp_last_ld) begin
                errors++;
                $display("FAIL rnd_load_data[%0d] got %h required %h", i, obs.ld_end, exp_last_ld);
            end
            if (!e.exc) begin
                checks++;
                if (obs.addr !== {addr[31:2], 2'b00} || obs.be !== e.be || obs.we !== wr || !obs.stable ||
                    (wr && obs.wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d] got addr=%h be=%b we=%b wdata=%h stable=%b required addr=%h be=%b we=%b wdata=%h stable=1",
                             i, obs.addr, obs.be, obs.we, obs.wdata, obs.stable, {addr[31:2], 2'b00}, e.be, wr, e.wdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

endmodule
